// File: rtl/parity_s_register_n.sv
// Parametrised S register with odd/even parity generation and checking, a sticky
// parity alarm with a saturating error counter, and the T12A editing-pulse sequencer.
module parity_s_register_n #(
  parameter int S_W     = 12,
  parameter int G_W     = 16,
  parameter int PAR_IDX = 14,
  parameter int ODD     = 1,
  parameter int CNT_W   = 4
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             GOJAM,
  input  logic [15:0]      WL,
  input  logic             WSG,
  input  logic             CSG,
  input  logic [G_W-1:0]   G,
  input  logic             MONPAR,
  input  logic             PCHK_EN,
  input  logic             GCHK,
  input  logic             EDIT_REQ,
  input  logic [1:0]       EDIT_SEL,
  input  logic             T12A,
  output logic [S_W-1:0]   S,
  output logic             PGEN,
  output logic             GEQZRO,
  output logic             PALE,
  output logic [CNT_W-1:0] PERR_CNT,
  output logic             CYR,
  output logic             SR,
  output logic             CYL,
  output logic             EDOP,
  output logic             EDIT_BUSY
);

  typedef enum logic {A_IDLE, A_ALARM} alarm_state_t;
  typedef enum logic {E_IDLE, E_PEND}  edit_state_t;

  localparam logic [G_W-1:0] PAR_MASK = G_W'(1) << PAR_IDX;
  localparam logic           ODD_BIT  = (ODD != 0);

  // S register: WSG wins over CSG; GOJAM deliberately leaves S alone.
  always_ff @(posedge SIM_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (SIM_RST)  S <= '0;
    else if (WSG) S <= WL[S_W-1:0];
    else if (CSG) S <= '0;
  end

  // Parity over every G bit except the parity position.
  logic [G_W-1:0] d_bits;
  logic           mismatch;
  logic           check;

  assign d_bits   = G & ~PAR_MASK;
  assign PGEN     = (^d_bits) ^ ODD_BIT ^ MONPAR;
  assign GEQZRO   = (d_bits == '0);
  assign mismatch = (G[PAR_IDX] != PGEN);
  assign check    = GCHK & PCHK_EN;

  alarm_state_t     alarm_q, alarm_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    alarm_next = alarm_q;
    cnt_next   = PERR_CNT;
    if (GOJAM) begin
      alarm_next = A_IDLE;
      cnt_next   = '0;
    end else if (check && mismatch) begin
      alarm_next = A_ALARM;
      if (PERR_CNT != '1) cnt_next = PERR_CNT + 1'b1;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      alarm_q  <= A_IDLE;
      PERR_CNT <= '0;
    end else begin
      alarm_q  <= alarm_next;
      PERR_CNT <= cnt_next;
    end
  end

  assign PALE = (alarm_q == A_ALARM);

  // Edit sequencer; pulse bit order is {EDOP, CYL, SR, CYR}.
  edit_state_t edit_q, edit_next;
  logic [1:0]  sel_q, sel_next;
  logic [3:0]  pulse_q, pulse_next;

  always_comb begin
    edit_next  = edit_q;
    sel_next   = sel_q;
    pulse_next = '0;
    if (!GOJAM) begin
      case (edit_q)
        E_IDLE: begin
          // A request arriving with T12A only arms the sequencer.
          if (EDIT_REQ) begin
            sel_next  = EDIT_SEL;
            edit_next = E_PEND;
          end
        end
        E_PEND: begin
          if (T12A) begin
            pulse_next = 4'b0001 << sel_q;
            if (!EDIT_REQ) edit_next = E_IDLE;
          end
          if (EDIT_REQ) sel_next = EDIT_SEL;
        end
        default: edit_next = E_IDLE;
      endcase
    end else begin
      edit_next = E_IDLE;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      edit_q  <= E_IDLE;
      sel_q   <= 2'd0;
      pulse_q <= '0;
    end else begin
      edit_q  <= edit_next;
      sel_q   <= sel_next;
      pulse_q <= pulse_next;
    end
  end

  assign CYR       = pulse_q[0];
  assign SR        = pulse_q[1];
  assign CYL       = pulse_q[2];
  assign EDOP      = pulse_q[3];
  assign EDIT_BUSY = (edit_q == E_PEND);

endmodule
